// File: rtl/cpu_pkg.sv
// Shared definitions for the bytecode CPU control path: control opcodes,
// the invoke/return sequencer state type and the method header layout.
package cpu_pkg;

  localparam logic [7:0] INVOKESTATIC = 8'hb8;
  localparam logic [7:0] RETURN       = 8'hb1;
  localparam logic [7:0] IRETURN      = 8'hac;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_PUSH_RA,
    S_WAIT_RA,
    S_PUSH_OFF,
    S_WAIT_OFF,
    S_ARGS,
    S_POP_ARG,
    S_WAIT_ARG,
    S_WR_ARG,
    S_WAIT_WR,
    S_JUMP,
    S_RPOP_RA,
    S_RWAIT_RA,
    S_RPOP_OFF,
    S_RWAIT_OFF
  } ictrl_state_t;

  // Method header as stored in the data segment.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  nargs;
    logic [7:0]  max_locals;
  } method_hdr_t;

endpackage

// File: rtl/invoke_ctrl.sv
// invoke_ctrl: sequences invokestatic / return / ireturn for the bytecode CPU.
// Invoke: fetch callee header, push return PC and caller LVA offset, move the
// arguments from the operand stack into the new frame, then load the callee PC.
// Return: pop return PC and LVA offset, then load the return PC.
// Every *_trigger is a one-cycle pulse issued from its own state; the matching
// *_done is only honoured in the wait state that follows, so a done arriving
// at any other time is ignored.
// Optional macro INVOKE_FRAME_CHECK_EN: frame overflow / nargs check with a
// sticky frame_err; without it the offset wraps modulo 256 and frame_err is 0.
module invoke_ctrl
  import cpu_pkg::*;
#(
  parameter int MAIN_LOCALS = 16,
  parameter int LVA_SIZE    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  op_code,
  input  logic [7:0]  arg1,
  input  logic [7:0]  arg2,
  input  logic [15:0] pc_in,
  output logic [15:0] dataindex,
  input  logic [31:0] dataparams,
  output logic        cs_push,
  output logic        cs_trigger,
  output logic [31:0] cs_write,
  input  logic [31:0] cs_read,
  input  logic        cs_done,
  output logic        os_push,
  output logic        os_trigger,
  output logic [31:0] os_write,
  input  logic [31:0] os_read,
  input  logic        os_done,
  output logic        op_trigger,
  input  logic [31:0] op_read,
  input  logic        op_done,
  output logic        lva_trigger,
  output logic        lva_write,
  output logic [7:0]  lva_addr,
  output logic [31:0] lva_in,
  input  logic        lva_done,
  output logic [7:0]  lva_offset,
  output logic [15:0] new_pc,
  output logic        pc_load,
  output logic        busy,
  output logic        frame_err,
  output logic [3:0]  dbg_state
);

  localparam logic [7:0] OFFSET_RST = 8'(MAIN_LOCALS - 1);
  localparam logic [8:0] LVA_MAX    = 9'(LVA_SIZE - 1);

  ictrl_state_t state_q, state_d;
  method_hdr_t  hdr_q, hdr_in;
  logic [7:0]   k_q;
  logic [31:0]  arg_q;
  logic [15:0]  ret_pc_q;
  logic [15:0]  call_pc_q;
  logic         frame_bad;
  logic         unused_bits;

  assign hdr_in      = method_hdr_t'(dataparams);
  assign unused_bits = ^{cs_read[31:16], os_read[31:8], LVA_MAX};

`ifdef INVOKE_FRAME_CHECK_EN
  logic frame_err_q;

  // Callee frame must fit below the LVA top and hold all of its arguments.
  assign frame_bad = (({1'b0, lva_offset} + {1'b0, hdr_in.max_locals}) > LVA_MAX) ||
                     (hdr_in.nargs > hdr_in.max_locals);

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else if (state_q == S_FETCH && frame_bad) begin
      frame_err_q <= 1'b1;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_bad = 1'b0;
  assign frame_err = 1'b0;
`endif

  // Combinational views of the datapath registers.
  assign busy      = (state_q != S_IDLE);
  assign lva_write = lva_trigger;
  assign lva_addr  = lva_offset - k_q + 8'd1;
  assign lva_in    = arg_q;
  assign cs_write  = {16'h0, call_pc_q + 16'd3};
  assign os_write  = {24'h0, lva_offset};
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: header, argument counter, frame base and jump target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataindex  <= 16'h0;
      call_pc_q  <= 16'h0;
      hdr_q      <= '0;
      k_q        <= 8'h0;
      arg_q      <= 32'h0;
      ret_pc_q   <= 16'h0;
      lva_offset <= OFFSET_RST;
      new_pc     <= 16'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && op_code == INVOKESTATIC) begin
            dataindex <= {arg1, arg2};
            call_pc_q <= pc_in;
          end
        end
        S_FETCH: begin
          hdr_q <= hdr_in;
          if (frame_bad) begin
            new_pc <= call_pc_q;
          end
        end
        S_WAIT_OFF: begin
          if (os_done) begin
            lva_offset <= lva_offset + hdr_q.max_locals;
            k_q        <= hdr_q.nargs;
          end
        end
        S_ARGS: begin
          if (k_q == 8'h0) begin
            new_pc <= hdr_q.addr;
          end
        end
        S_WAIT_ARG: begin
          if (op_done) begin
            arg_q <= op_read;
          end
        end
        S_WAIT_WR: begin
          if (lva_done) begin
            k_q <= k_q - 8'd1;
          end
        end
        S_RWAIT_RA: begin
          if (cs_done) begin
            ret_pc_q <= cs_read[15:0];
          end
        end
        S_RWAIT_OFF: begin
          if (os_done) begin
            lva_offset <= os_read[7:0];
            new_pc     <= ret_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and one-cycle handshake outputs.
  always_comb begin
    state_d     = state_q;
    cs_push     = 1'b0;
    cs_trigger  = 1'b0;
    os_push     = 1'b0;
    os_trigger  = 1'b0;
    op_trigger  = 1'b0;
    lva_trigger = 1'b0;
    pc_load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_code == INVOKESTATIC) begin
            state_d = S_FETCH;
          end else if (op_code == RETURN || op_code == IRETURN) begin
            state_d = S_RPOP_RA;
          end
        end
      end
      S_FETCH:     state_d = frame_bad ? S_JUMP : S_PUSH_RA;
      S_PUSH_RA: begin
        cs_trigger = 1'b1;
        cs_push    = 1'b1;
        state_d    = S_WAIT_RA;
      end
      S_WAIT_RA:   if (cs_done) state_d = S_PUSH_OFF;
      S_PUSH_OFF: begin
        os_trigger = 1'b1;
        os_push    = 1'b1;
        state_d    = S_WAIT_OFF;
      end
      S_WAIT_OFF:  if (os_done) state_d = S_ARGS;
      S_ARGS:      state_d = (k_q == 8'h0) ? S_JUMP : S_POP_ARG;
      S_POP_ARG: begin
        op_trigger = 1'b1;
        state_d    = S_WAIT_ARG;
      end
      S_WAIT_ARG:  if (op_done) state_d = S_WR_ARG;
      S_WR_ARG: begin
        lva_trigger = 1'b1;
        state_d     = S_WAIT_WR;
      end
      S_WAIT_WR:   if (lva_done) state_d = S_ARGS;
      S_JUMP: begin
        pc_load = 1'b1;
        state_d = S_IDLE;
      end
      S_RPOP_RA: begin
        cs_trigger = 1'b1;
        state_d    = S_RWAIT_RA;
      end
      S_RWAIT_RA:  if (cs_done) state_d = S_RPOP_OFF;
      S_RPOP_OFF: begin
        os_trigger = 1'b1;
        state_d    = S_RWAIT_OFF;
      end
      S_RWAIT_OFF: if (os_done) state_d = S_JUMP;
      default:     state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_invoke_ctrl.sv
// Bench for invoke_ctrl: behavioural call-stack / offset-stack / operand-stack
// / LVA models answer the handshakes with programmable done delays; a
// reference model of the call frames predicts PCs, offsets and LVA writes.
module tb_invoke_ctrl;
  import cpu_pkg::*;

  localparam int MAIN_LOCALS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  op_code = 8'h0;
  logic [7:0]  arg1 = 8'h0;
  logic [7:0]  arg2 = 8'h0;
  logic [15:0] pc_in = 16'h0;
  logic [15:0] dataindex;
  logic [31:0] dataparams;
  logic        cs_push, cs_trigger;
  logic [31:0] cs_write;
  logic [31:0] cs_read = 32'h0;
  logic        cs_done = 1'b0;
  logic        os_push, os_trigger;
  logic [31:0] os_write;
  logic [31:0] os_read = 32'h0;
  logic        os_done = 1'b0;
  logic        op_trigger;
  logic [31:0] op_read = 32'h0;
  logic        op_done = 1'b0;
  logic        lva_trigger, lva_write;
  logic [7:0]  lva_addr;
  logic [31:0] lva_in;
  logic        lva_done = 1'b0;
  logic [7:0]  lva_offset;
  logic [15:0] new_pc;
  logic        pc_load, busy, frame_err;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Environment state: bus-side stacks, data segment entry, done delays.
  logic [15:0] cs_mem[$];
  logic [7:0]  os_mem[$];
  logic [31:0] op_mem[$];
  logic [15:0] hdr_idx = 16'h0;
  logic [31:0] hdr_val = 32'h0;
  int cs_dly = 1, os_dly = 1, op_dly = 1, lva_dly = 1;
  int cs_cnt = 0, os_cnt = 0, op_cnt = 0, lva_cnt = 0;
  int trig_viol = 0;
  logic [4:0] trig_prev = 5'h0;

  // Scoreboard of expected LVA writes {addr, data} and reference call frames.
  logic [39:0] exp_q[$];
  logic [15:0] ref_ra[$];
  logic [7:0]  ref_off[$];
  logic [7:0]  ref_offset = 8'(MAIN_LOCALS - 1);
  bit          ref_err = 1'b0;
  logic [15:0] last_idx = 16'h0;

  invoke_ctrl #(.MAIN_LOCALS(MAIN_LOCALS), .LVA_SIZE(256)) dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code), .arg1(arg1),
    .arg2(arg2), .pc_in(pc_in), .dataindex(dataindex), .dataparams(dataparams),
    .cs_push(cs_push), .cs_trigger(cs_trigger), .cs_write(cs_write),
    .cs_read(cs_read), .cs_done(cs_done), .os_push(os_push),
    .os_trigger(os_trigger), .os_write(os_write), .os_read(os_read),
    .os_done(os_done), .op_trigger(op_trigger), .op_read(op_read),
    .op_done(op_done), .lva_trigger(lva_trigger), .lva_write(lva_write),
    .lva_addr(lva_addr), .lva_in(lva_in), .lva_done(lva_done),
    .lva_offset(lva_offset), .new_pc(new_pc), .pc_load(pc_load), .busy(busy),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    cs_mem.delete(); os_mem.delete(); op_mem.delete(); exp_q.delete();
    ref_ra.delete(); ref_off.delete();
    ref_offset = 8'(MAIN_LOCALS - 1);
    ref_err = 1'b0;
    last_idx = 16'h0;
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Data segment: only the currently programmed index returns a header.
  assign dataparams = (dataindex == hdr_idx) ? hdr_val : 32'hdead_beef;

  // ---------------- environment models ----------------
  // Call stack.
  always @(negedge clk) begin
    cs_done = 1'b0;
    if (rst) cs_cnt = 0;
    else begin
      if (cs_cnt > 0) begin
        cs_cnt--;
        if (cs_cnt == 0) cs_done = 1'b1;
      end
      if (cs_trigger) begin
        if (cs_push) begin
          chk("cs_write_hi", 40'(cs_write[31:16]), 40'h0);
          cs_mem.push_back(cs_write[15:0]);
        end else if (cs_mem.size() > 0) cs_read = {16'hbeef, cs_mem.pop_back()};
        else cs_read = 32'hbeef_ffff;
        cs_cnt = cs_dly;
      end
    end
  end

  // LVA-offset stack.
  always @(negedge clk) begin
    os_done = 1'b0;
    if (rst) os_cnt = 0;
    else begin
      if (os_cnt > 0) begin
        os_cnt--;
        if (os_cnt == 0) os_done = 1'b1;
      end
      if (os_trigger) begin
        if (os_push) begin
          chk("os_write_hi", 40'(os_write[31:8]), 40'h0);
          os_mem.push_back(os_write[7:0]);
        end else if (os_mem.size() > 0) os_read = {24'hc0ffee, os_mem.pop_back()};
        else os_read = 32'hc0ff_eeff;
        os_cnt = os_dly;
      end
    end
  end

  // Operand stack (pop only).
  always @(negedge clk) begin
    op_done = 1'b0;
    if (rst) op_cnt = 0;
    else begin
      if (op_cnt > 0) begin
        op_cnt--;
        if (op_cnt == 0) op_done = 1'b1;
      end
      if (op_trigger) begin
        op_read = (op_mem.size() > 0) ? op_mem.pop_back() : 32'hbad0_bad0;
        op_cnt = op_dly;
      end
    end
  end

  // LVA: every write is checked against the scoreboard.
  always @(negedge clk) begin
    lva_done = 1'b0;
    if (rst) lva_cnt = 0;
    else begin
      if (lva_cnt > 0) begin
        lva_cnt--;
        if (lva_cnt == 0) lva_done = 1'b1;
      end
      if (lva_trigger) begin
        n_checks++;
        assert (exp_q.size() > 0) else begin
          n_errors++;
          $error("FAIL lva_unexpected: observed write addr 0x%0h data 0x%0h, expected none", lva_addr, lva_in);
        end
        if (exp_q.size() > 0) chk("lva_write_data", {lva_addr, lva_in}, exp_q.pop_front());
        chk("lva_write_en", 40'(lva_write), 40'h1);
        lva_cnt = lva_dly;
      end
    end
  end

  // Handshake pulses must never last two cycles.
  always @(negedge clk) begin
    if (rst) trig_prev = 5'h0;
    else begin
      if (({cs_trigger, os_trigger, op_trigger, lva_trigger, pc_load} & trig_prev) != 5'h0)
        trig_viol++;
      trig_prev = {cs_trigger, os_trigger, op_trigger, lva_trigger, pc_load};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [7:0] op, input logic [15:0] idx, input logic [15:0] pc);
    @(negedge clk);
    start = 1'b1; op_code = op; arg1 = idx[15:8]; arg2 = idx[7:0]; pc_in = pc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_load(input string tag, input logic [15:0] exp_pc, input bit inject);
    int cyc = 0;
    int busy_low = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 400) begin
      if (pc_load) seen = 1'b1;
      else begin
        if (!busy) busy_low++;
        if (inject && cyc == 2) begin
          start = 1'b1; op_code = INVOKESTATIC; arg1 = 8'h00; arg2 = 8'h07;
        end else start = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    n_checks++;
    assert (seen) else begin
      n_errors++;
      $error("FAIL %s_timeout: observed no pc_load in %0d cycles, expected pc_load", tag, cyc);
    end
    chk({tag, "_busy_hold"}, 40'(busy_low), 40'h0);
    if (seen) begin
      chk({tag, "_new_pc"}, 40'(new_pc), 40'(exp_pc));
      chk({tag, "_busy_at_load"}, 40'(busy), 40'h1);
      @(negedge clk);
      chk({tag, "_busy_drop"}, 40'(busy), 40'h0);
      chk({tag, "_pc_load_pulse"}, 40'(pc_load), 40'h0);
    end
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_lva_offset"}, 40'(lva_offset), 40'(ref_offset));
    chk({tag, "_lva_left"}, 40'(exp_q.size()), 40'h0);
    chk({tag, "_cs_depth"}, 40'(cs_mem.size()), 40'(ref_ra.size()));
    chk({tag, "_os_depth"}, 40'(os_mem.size()), 40'(ref_off.size()));
    chk({tag, "_frame_err"}, 40'(frame_err), 40'(ref_err));
    if (cs_mem.size() > 0 && ref_ra.size() > 0) chk({tag, "_ra_top"}, 40'(cs_mem[$]), 40'(ref_ra[$]));
    if (os_mem.size() > 0 && ref_off.size() > 0) chk({tag, "_off_top"}, 40'(os_mem[$]), 40'(ref_off[$]));
  endtask

  // Arguments are given in source order: args[0] is pushed first, so the
  // last argument is on top of the operand stack. Slot s of the new frame
  // sits at address (new frame base - s).
  task automatic do_invoke(input string tag, input logic [15:0] pc, input logic [15:0] idx,
                           input logic [15:0] maddr, input int ml, input logic [31:0] args[$],
                           input bit inject);
    logic [7:0] old_off, new_off;
    int nargs, op_before;
    bit bad;
    nargs = args.size();
    old_off = ref_offset;
    new_off = old_off + 8'(ml);
    bad = 1'b0;
`ifdef INVOKE_FRAME_CHECK_EN
    bad = (int'(old_off) + ml > 255) || (nargs > ml);
`endif
    hdr_idx = idx;
    hdr_val = {maddr, 8'(nargs), 8'(ml)};
    op_before = op_mem.size();
    foreach (args[i]) op_mem.push_back(args[i]);
    if (!bad) for (int s = nargs - 1; s >= 0; s--) exp_q.push_back({new_off - 8'(s), args[s]});
    pulse_start(INVOKESTATIC, idx, pc);
    chk({tag, "_dataindex"}, 40'(dataindex), 40'(idx));
    last_idx = idx;
    wait_load(tag, bad ? pc : maddr, inject);
    if (bad) begin
      ref_err = 1'b1;
      chk({tag, "_op_untouched"}, 40'(op_mem.size()), 40'(op_before + nargs));
      while (op_mem.size() > op_before) void'(op_mem.pop_back());
    end else begin
      ref_ra.push_back(pc + 16'd3);
      ref_off.push_back(old_off);
      ref_offset = new_off;
      chk({tag, "_op_consumed"}, 40'(op_mem.size()), 40'(op_before));
    end
    check_frames(tag);
  endtask

  task automatic do_return(input string tag, input logic [7:0] op, input logic [15:0] pc, input bit inject);
    logic [15:0] exp_pc;
    logic [31:0] top;
    int op_before;
    exp_pc = ref_ra[$];
    if (op == IRETURN) op_mem.push_back($urandom);
    op_before = op_mem.size();
    top = (op_before > 0) ? op_mem[$] : 32'h0;
    pulse_start(op, 16'hffff, pc);
    wait_load(tag, exp_pc, inject);
    void'(ref_ra.pop_back());
    ref_offset = ref_off.pop_back();
    chk({tag, "_op_depth"}, 40'(op_mem.size()), 40'(op_before));
    if (op_before > 0 && op_mem.size() > 0) chk({tag, "_op_top"}, 40'(op_mem[$]), 40'(top));
    check_frames(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_lva_offset"}, 40'(lva_offset), 40'(MAIN_LOCALS - 1));
    chk({tag, "_busy"}, 40'(busy), 40'h0);
    chk({tag, "_triggers"}, 40'({cs_trigger, cs_push, os_trigger, os_push, op_trigger, lva_trigger}), 40'h0);
    chk({tag, "_pc_load"}, 40'(pc_load), 40'h0);
    chk({tag, "_new_pc"}, 40'(new_pc), 40'h0);
    chk({tag, "_dataindex"}, 40'(dataindex), 40'h0);
    chk({tag, "_frame_err"}, 40'(frame_err), 40'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] args[$];
    int cyc;
    bit hit;

    apply_reset();
    @(negedge clk);
    check_reset_vals("reset");

    // Single call/return with 1-cycle done models; args 9 then 7 pushed.
    args = '{32'd9, 32'd7};
    do_invoke("inv_basic", 16'h0010, 16'h0002, 16'h0040, 3, args, 1'b0);
    do_return("ret_basic", RETURN, 16'h0045, 1'b0);

    // Unknown opcode is ignored.
    pulse_start(8'h60, 16'h0102, 16'h0200);
    repeat (3) begin
      chk("ignore_busy", 40'(busy), 40'h0);
      @(negedge clk);
    end
    chk("ignore_dataindex", 40'(dataindex), 40'(last_idx));

    // Nested calls with 3-cycle done delays and starts injected while busy.
    cs_dly = 3; os_dly = 3; op_dly = 3; lva_dly = 3;
    args = '{32'h1111_0001};
    do_invoke("inv_outer", 16'h0100, 16'h0010, 16'h0300, 4, args, 1'b1);
    args = '{32'h2222_0001, 32'h2222_0002, 32'h2222_0003};
    do_invoke("inv_inner", 16'h0305, 16'h0011, 16'h0500, 5, args, 1'b1);
    do_return("ret_inner", IRETURN, 16'h0510, 1'b1);
    do_return("ret_outer", RETURN, 16'h0320, 1'b1);

    // Frame base near the LVA top: wraps, or trips the frame check.
    cs_dly = 1; os_dly = 2; op_dly = 1; lva_dly = 2;
    args.delete();
    do_invoke("inv_to250", 16'h0020, 16'h0030, 16'h0700, 235, args, 1'b0);
    args = '{32'haaaa_0000, 32'hbbbb_1111};
    do_invoke("inv_edge", 16'h0702, 16'h0031, 16'h0800, 10, args, 1'b0);
    while (ref_ra.size() > 0) do_return("ret_edge", RETURN, 16'h0900, 1'b0);

    // Randomized call trees.
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      cs_dly = $urandom_range(1, 4); os_dly = $urandom_range(1, 4);
      op_dly = $urandom_range(1, 4); lva_dly = $urandom_range(1, 4);
      if (ref_ra.size() > 0 && ($urandom_range(0, 1) == 1 || ref_ra.size() >= 6)) begin
        do_return("rnd_ret", ($urandom_range(0, 1) == 1) ? RETURN : IRETURN,
                  16'($urandom), 1'b0);
      end else begin
        int n, ml;
        args.delete();
        n = $urandom_range(0, 4);
        ml = $urandom_range(n, n + 12);
        for (int i = 0; i < n; i++) args.push_back($urandom);
        do_invoke("rnd_inv", 16'($urandom_range(0, 16'hfff0)), 16'($urandom),
                  16'($urandom), ml, args, 1'b0);
      end
    end
    while (ref_ra.size() > 0) do_return("rnd_unwind", RETURN, 16'h1234, 1'b0);

    // Asynchronous reset in the middle of argument transfer.
    apply_reset();
    lva_dly = 6;
    hdr_idx = 16'h0040;
    hdr_val = {16'h0a00, 8'd3, 8'd4};
    op_mem.push_back(32'h0000_000a); op_mem.push_back(32'h0000_000b); op_mem.push_back(32'h0000_000c);
    exp_q.push_back({8'd17, 32'h0000_000c});
    exp_q.push_back({8'd18, 32'h0000_000b});
    exp_q.push_back({8'd19, 32'h0000_000a});
    pulse_start(INVOKESTATIC, 16'h0040, 16'h0a00);
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 100) begin
      if (lva_trigger) hit = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    n_checks++;
    assert (hit) else begin
      n_errors++;
      $error("FAIL midargs_timeout: observed no lva_trigger in %0d cycles, expected one", cyc);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    apply_reset();
    @(negedge clk);
    check_reset_vals("after_rst");

    chk("trigger_width", 40'(trig_viol), 40'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
